// File: rtl/mem_responder.sv
// Byte RAM plus memory-mapped TX/RX FIFOs, status and halt; reads return 1 cycle after the address.
// TX full drops IO writes unless the host pops that cycle; rxReady deasserts while the RX FIFO is full.
module mem_responder #(
  parameter int ADDR_WIDTH = 17,
  parameter int FIFO_WIDTH = 3,
  parameter int FIFO_DEPTH = 2**FIFO_WIDTH
) (
  input  logic        clkIn,
  input  logic        resetIn,
  input  logic        readWriteIn,
  input  logic [31:0] memAddrIn,
  input  logic [7:0]  memDataIn,
  output logic [7:0]  memDataOut,
  output logic [7:0]  txData,
  output logic        txValid,
  input  logic        txReady,
  input  logic [7:0]  rxData,
  input  logic        rxValid,
  output logic        rxReady,
  output logic        ioFull,
  output logic        haltOut
);
  localparam int TX = 0;
  localparam int RX = 1;
  localparam logic [FIFO_WIDTH:0] DEPTH_C = (FIFO_WIDTH+1)'(FIFO_DEPTH);

  logic [7:0] ram [0:2**ADDR_WIDTH-1];
  logic [ADDR_WIDTH-1:0] ramIdx;
  logic isIo, ioData, ioStatus;
  logic overflow, rxNonEmpty;
  logic txPop, txDropped;
  logic [7:0] ioByte, statusByte;
  logic [1:0] fifoPush, fifoPop;
  logic [1:0][7:0] fifoDin;
  logic unusedAddrBits;

  assign ramIdx         = memAddrIn[ADDR_WIDTH-1:0];
  assign isIo           = memAddrIn[17:16] == 2'b11;
  assign ioData         = isIo && (memAddrIn[15:0] == 16'h0000);
  assign ioStatus       = isIo && (memAddrIn[15:0] == 16'h0004);
  assign unusedAddrBits = ^memAddrIn[31:18];

  assign txPop        = txValid && txReady;
  assign fifoPush[TX] = readWriteIn && ioData;
  assign fifoPop[TX]  = txPop;
  assign fifoPush[RX] = rxValid && rxReady;
  assign fifoPop[RX]  = !readWriteIn && ioData;
  assign fifoDin      = {rxData, memDataIn};

  // One FIFO body shared by TX and RX; a push while full lands only alongside a pop.
  for (genvar f = 0; f < 2; f++) begin : gFifo
    logic [7:0] mem [FIFO_DEPTH];
    logic [FIFO_WIDTH-1:0] rdPtr, wrPtr;
    logic [FIFO_WIDTH:0] count;
    logic doPush, doPop;

    assign doPop  = fifoPop[f] && (count != '0);
    assign doPush = fifoPush[f] && ((count != DEPTH_C) || doPop);

    always_ff @(posedge clkIn) begin
      if (doPush) mem[wrPtr] <= fifoDin[f];
    end

    always_ff @(posedge clkIn or negedge resetIn) begin
      if (!resetIn) begin
        rdPtr <= '0;
        wrPtr <= '0;
        count <= '0;
      end else begin
        if (doPush) wrPtr <= wrPtr + 1'b1;
        if (doPop) rdPtr <= rdPtr + 1'b1;
        if (doPush && !doPop) count <= count + 1'b1;
        else if (doPop && !doPush) count <= count - 1'b1;
      end
    end
  end

  assign txData     = gFifo[TX].mem[gFifo[TX].rdPtr];
  assign txValid    = gFifo[TX].count != '0;
  assign ioFull     = gFifo[TX].count == DEPTH_C;
  assign rxReady    = gFifo[RX].count != DEPTH_C;
  assign rxNonEmpty = gFifo[RX].count != '0;
  assign txDropped  = fifoPush[TX] && ioFull && !txPop;
  assign statusByte = {haltOut, 4'b0000, overflow, ioFull, rxNonEmpty};

  always_comb begin
    ioByte = 8'h00;
    if (ioData && rxNonEmpty) ioByte = gFifo[RX].mem[gFifo[RX].rdPtr];
    else if (ioStatus) ioByte = statusByte;
  end

  always_ff @(posedge clkIn) begin
    if (readWriteIn && !isIo) ram[ramIdx] <= memDataIn;
  end

  // memDataOut holds across writes so the controller can consume it late.
  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      memDataOut <= 8'h00;
      haltOut    <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (!readWriteIn) memDataOut <= isIo ? ioByte : ram[ramIdx];
      if (readWriteIn && ioStatus) haltOut <= 1'b1;
      if (txDropped) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// Drives directed and random accesses into mem_responder and checks every cycle against a queue-based model.
module tb_mem_responder;
  logic clkIn = 1'b0;
  always #5 clkIn = ~clkIn;

  logic        resetIn, readWriteIn, txReady, rxValid;
  logic [31:0] memAddrIn;
  logic [7:0]  memDataIn, rxData, memDataOut, txData;
  logic        txValid, rxReady, ioFull, haltOut;

  mem_responder dut (
    .clkIn(clkIn), .resetIn(resetIn), .readWriteIn(readWriteIn),
    .memAddrIn(memAddrIn), .memDataIn(memDataIn), .memDataOut(memDataOut),
    .txData(txData), .txValid(txValid), .txReady(txReady),
    .rxData(rxData), .rxValid(rxValid), .rxReady(rxReady),
    .ioFull(ioFull), .haltOut(haltOut)
  );

  int nCompared = 0;
  int nMismatch = 0;

  logic [7:0] ramM [int];
  logic [7:0] txQ [$];
  logic [7:0] rxQ [$];
  logic       haltM, ovfM, memKnownM;
  logic [7:0] memOutM;
  logic       checkEn = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    txQ.delete();
    rxQ.delete();
    haltM = 1'b0;
    ovfM = 1'b0;
    memOutM = 8'h00;
    memKnownM = 1'b1;
  endtask

  task automatic driveIdle();
    readWriteIn = 1'b1;
    memAddrIn = 32'h0003000C;
    memDataIn = 8'h00;
    txReady = 1'b0;
    rxValid = 1'b0;
    rxData = 8'h00;
  endtask

  // One access cycle: drive at negedge, then advance the model at the posedge that consumes it.
  task automatic cyc(input logic rw, input logic [31:0] a, input logic [7:0] d,
                     input logic txr, input logic rxv, input logic [7:0] rxd);
    logic isIo, txPop, rxPush;
    logic [16:0] idx;
    logic [7:0] status;
    @(negedge clkIn);
    readWriteIn = rw; memAddrIn = a; memDataIn = d;
    txReady = txr; rxValid = rxv; rxData = rxd;
    @(posedge clkIn);
    isIo = (a[17:16] == 2'b11);
    idx = a[16:0];
    txPop = txr && (txQ.size() != 0);
    rxPush = rxv && (rxQ.size() != 8);
    status = {haltM, 4'b0000, ovfM, txQ.size() == 8, rxQ.size() != 0};
    if (txPop) void'(txQ.pop_front());
    if (rw) begin
      if (!isIo) ramM[int'(idx)] = d;
      else if (a == 32'h00030000) begin
        if (txQ.size() < 8) txQ.push_back(d);
        else ovfM = 1'b1;
      end else if (a == 32'h00030004) haltM = 1'b1;
    end else begin
      memKnownM = 1'b1;
      if (!isIo) begin
        if (ramM.exists(int'(idx))) memOutM = ramM[int'(idx)];
        else memKnownM = 1'b0;
      end else if (a == 32'h00030000 && rxQ.size() != 0) memOutM = rxQ.pop_front();
      else if (a == 32'h00030004) memOutM = status;
      else memOutM = 8'h00;
    end
    if (rxPush) rxQ.push_back(rxd);
  endtask

  task automatic idle(input logic txr, input logic rxv, input logic [7:0] rxd);
    cyc(1'b1, 32'h0003000C, 8'h00, txr, rxv, rxd);
  endtask

  always @(negedge clkIn) begin
    if (checkEn && resetIn) begin
      if (memKnownM) check("memDataOut", memDataOut, memOutM);
      check("txValid", 8'(txValid), 8'(txQ.size() != 0));
      if (txQ.size() != 0) check("txData", txData, txQ[0]);
      check("ioFull", 8'(ioFull), 8'(txQ.size() == 8));
      check("rxReady", 8'(rxReady), 8'(rxQ.size() != 8));
      check("haltOut", 8'(haltOut), 8'(haltM));
    end
  end

  initial begin
    logic [31:0] a;
    resetIn = 1'b0;
    driveIdle();
    modelReset();
    repeat (3) @(negedge clkIn);
    check("rst memDataOut", memDataOut, 8'h00);
    check("rst txValid", 8'(txValid), 8'h00);
    check("rst rxReady", 8'(rxReady), 8'h01);
    check("rst ioFull", 8'(ioFull), 8'h00);
    check("rst haltOut", 8'(haltOut), 8'h00);
    resetIn = 1'b1;
    checkEn = 1'b1;

    cyc(1'b1, 32'h00011, 8'h11, 1'b0, 1'b0, 8'h00);
    cyc(1'b1, 32'h00010, 8'hA5, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 32'h00010, 8'h00, 1'b0, 1'b0, 8'h00);
    #1 check("ram read 0x10", memDataOut, 8'hA5);
    cyc(1'b0, 32'h00011, 8'h00, 1'b0, 1'b0, 8'h00);
    #1 check("ram read 0x11", memDataOut, 8'h11);

    cyc(1'b1, 32'h30000, 8'h48, 1'b0, 1'b0, 8'h00);
    cyc(1'b1, 32'h30000, 8'h69, 1'b0, 1'b0, 8'h00);
    #1 check("tx head", txData, 8'h48);
    check("tx valid", 8'(txValid), 8'h01);
    idle(1'b1, 1'b0, 8'h00);
    #1 check("tx second", txData, 8'h69);
    idle(1'b1, 1'b0, 8'h00);
    #1 check("tx drained", 8'(txValid), 8'h00);

    idle(1'b0, 1'b1, 8'h31);
    cyc(1'b0, 32'h30004, 8'h00, 1'b0, 1'b0, 8'h00);
    #1 check("rx status", memDataOut, 8'h01);
    cyc(1'b0, 32'h30000, 8'h00, 1'b0, 1'b0, 8'h00);
    #1 check("rx pop", memDataOut, 8'h31);
    cyc(1'b0, 32'h30000, 8'h00, 1'b0, 1'b0, 8'h00);
    #1 check("rx empty pop", memDataOut, 8'h00);
    cyc(1'b0, 32'h30004, 8'h00, 1'b0, 1'b0, 8'h00);
    #1 check("rx status empty", memDataOut, 8'h00);

    for (int i = 0; i < 8; i++) cyc(1'b1, 32'h30000, 8'(8'h80 + i), 1'b0, 1'b0, 8'h00);
    #1 check("tx full", 8'(ioFull), 8'h01);
    cyc(1'b1, 32'h30000, 8'h77, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 32'h30004, 8'h00, 1'b0, 1'b0, 8'h00);
    #1 check("overflow status", memDataOut, 8'h06);
    cyc(1'b1, 32'h30000, 8'h78, 1'b1, 1'b0, 8'h00);
    #1 check("full push+pop ioFull", 8'(ioFull), 8'h01);
    check("full push+pop head", txData, 8'h81);
    repeat (8) idle(1'b1, 1'b0, 8'h00);
    #1 check("tx drain empty", 8'(txValid), 8'h00);

    cyc(1'b1, 32'h30004, 8'hFF, 1'b0, 1'b0, 8'h00);
    #1 check("halt set", 8'(haltOut), 8'h01);
    cyc(1'b0, 32'h30004, 8'h00, 1'b0, 1'b0, 8'h00);
    #1 check("halt status", memDataOut, 8'h84);
    cyc(1'b1, 32'h30000, 8'h55, 1'b0, 1'b0, 8'h00);

    #2 resetIn = 1'b0;
    modelReset();
    driveIdle();
    #1 check("async haltOut", 8'(haltOut), 8'h00);
    check("async txValid", 8'(txValid), 8'h00);
    check("async memDataOut", memDataOut, 8'h00);
    repeat (2) @(negedge clkIn);
    resetIn = 1'b1;

    cyc(1'b1, 32'h00010, 8'h5A, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 32'h20010, 8'h00, 1'b0, 1'b0, 8'h00);
    #1 check("alias read", memDataOut, 8'h5A);

    repeat (3000) begin
      case ($urandom_range(0, 3))
        0: a = 32'h00030000;
        1: a = 32'h00030000 + 32'(4 * $urandom_range(1, 2));
        default: a = (32'($urandom_range(0, 1)) << 17) | 32'($urandom_range(0, 31));
      endcase
      cyc(1'($urandom_range(0, 1)), a, 8'($urandom), $urandom_range(0, 3) == 0,
          1'($urandom_range(0, 1)), 8'($urandom));
    end

    checkEn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Byte-wide memory responder on the far side of the cache/memory controller's RAM port.
- Serves one byte read or write per cycle from an internal byte RAM.
- Decodes the memory-mapped IO window (addr[17:16] == 2'b11) into a transmit FIFO, a receive FIFO, a status register and a halt register.
- Sits at SoC top level, between the CPU memory port and the host/UART-side byte streams.

Parameters:
ADDR_WIDTH, 17, RAM index width; RAM holds 2**ADDR_WIDTH bytes.
FIFO_WIDTH, 3, log2 depth of each IO FIFO.
FIFO_DEPTH, 2**FIFO_WIDTH, entries per IO FIFO.

Ports:
clkIn  input  1  system clock
resetIn  input  1  reset, asynchronous, active-low
readWriteIn  input  1  access type from the controller: 0 = read, 1 = write
memAddrIn  input  32  byte address
memDataIn  input  8  write data
memDataOut  output  8  read data, registered
txData  output  8  head byte of the TX FIFO
txValid  output  1  TX FIFO non-empty
txReady  input  1  host accepts txData this cycle
rxData  input  8  byte from host
rxValid  input  1  rxData valid
rxReady  output  1  RX FIFO not full
ioFull  output  1  TX FIFO full; the controller stalls IO writes while high
haltOut  output  1  program-end flag

Behaviour:
- Reset (resetIn low, asynchronous): memDataOut=0, both FIFO pointers and counts=0, txValid=0, rxReady=1, ioFull=0, haltOut=0, overflow=0. RAM contents are not cleared. Deassertion takes effect at the next posedge.
- Decode: IO when memAddrIn[17:16]==2'b11; otherwise RAM, index memAddrIn[ADDR_WIDTH-1:0] (upper bits ignored).
- There is no request-valid signal; every cycle is an access.
  - A read with no IO side effect is harmless.
  - A read of 0x30000 pops the RX FIFO. Idle reads of 0x30000 are forbidden to the controller.
- RAM read: memDataOut <= ram[index] at posedge. Data is valid exactly 1 cycle after the address is presented. memDataOut holds its value until the next read.
- RAM write: ram[index] <= memDataIn at posedge. memDataOut is unchanged.
- IO reads: registered with the same 1-cycle latency.
  - 0x30000: if the RX FIFO is non-empty, return the head and pop it. Otherwise return 8'h00 with no pop.
  - 0x30004: status = {haltOut, 4'b0, overflow, ioFull, rxNonEmpty}.
  - Any other IO address returns 8'h00.
- IO writes:
  - 0x30000: push memDataIn into the TX FIFO. If the FIFO is full and not popping in the same cycle, drop the byte and set overflow (sticky until reset).
  - 0x30004: haltOut <= 1 (sticky until reset).
  - Any other IO address: write ignored.
- TX FIFO:
  - txData = head, txValid = count != 0.
  - Pop on txValid && txReady.
  - Push and pop in the same cycle: count unchanged. This holds when full (the push is accepted) and when count==1.
  - ioFull = count == FIFO_DEPTH.
- RX FIFO:
  - Push on rxValid && rxReady; rxReady = count != FIFO_DEPTH.
  - Push and CPU pop in the same cycle: both take effect; the popped byte is the old head. An empty FIFO is never popped; a push into an empty FIFO is visible to reads one cycle later.
- Pointers: FIFO_WIDTH bits, wrap modulo FIFO_DEPTH. Count is FIFO_WIDTH+1 bits.
- Reset mid-transfer: FIFO contents are abandoned. A pending read returns 0 after reset.

Test Plan:
- Reset, then write 0xA5 to 0x00010, read 0x00010 -> memDataOut==0xA5 on the cycle after the read address; the next cycle's read of 0x00011 returns the pre-loaded byte.
- Write 0x48, 0x69 to 0x30000 with txReady=0 -> txValid=1, txData=0x48; raise txReady for 2 cycles -> 0x48 then 0x69 leave, txValid=0.
- Fill TX with 8 writes (txReady=0) -> ioFull=1. Ninth write 0x77 -> dropped, status bit2=1. Ninth write with txReady=1 in the same cycle -> accepted, ioFull stays 1.
- Host pushes 0x31 via rxValid; read 0x30004 -> 0x01; read 0x30000 -> 0x31; read 0x30000 again -> 0x00; read 0x30004 -> 0x00.
- Write any byte to 0x30004 -> haltOut=1 next cycle; status bit7=1. Pull resetIn low asynchronously mid-cycle -> haltOut, txValid, memDataOut drop to 0 immediately.
- Address 0x20010 vs 0x00010 (ADDR_WIDTH=17): write 0x5A to 0x00010, read 0x20010 -> index 0x0_0010 aliasing rule gives 0x5A.
